// File: rtl/dpath_seq.sv
// Program sequencer for the accumulator datapath: fetches from an async-read ROM,
// drives dpath com/datain one ALU operation at a time, handles jumps and HALT.
//
// state    | meaning
// S_IDLE   | waiting for start; pc holds last value
// S_DECODE | opword at pc decoded; jumps/NOP/HALT retire here
// S_EXEC   | operand word at pc driven to dpath with latched ALU op
// S_DONE   | one-cycle done pulse, then IDLE
`ifndef SEL_W
`define SEL_W 3
`endif
`ifndef DATA_W
`define DATA_W 16
`endif

module dpath_seq #(
  parameter int               SEL_W   = `SEL_W,
  parameter int               DATA_W  = `DATA_W,
  parameter int               ADDR_W  = 8,
  parameter logic [SEL_W-1:0] COM_NOP = 3'b000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic [DATA_W-1:0] accum,
  output logic [SEL_W-1:0]  com,
  output logic [DATA_W-1:0] datain,
  output logic              busy,
  output logic              done,
  output logic [15:0]       icount
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, pc_inc, target;
  logic [2:0]         aluop_q, aluop_d;
  logic [15:0]        icount_q, icount_d, icount_inc;
  logic [SEL_W-1:0]   com_q;
  logic               busy_q, done_q, exec_q;
  logic [3:0]         op;
  logic               acc_zero;

  assign op         = imem_data[15:12];
  assign target     = imem_data[ADDR_W-1:0];
  assign pc_inc     = pc_q + ADDR_W'(1);
  assign acc_zero   = (accum == '0);
  assign icount_inc = (icount_q == 16'hFFFF) ? icount_q : icount_q + 16'd1;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    aluop_d  = aluop_q;
    icount_d = icount_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d     = '0;
          icount_d = '0;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!op[3]) begin
          aluop_d = op[2:0];
          pc_d    = pc_inc;
          state_d = S_EXEC;
        end else begin
          icount_d = icount_inc;
          case (op)
            4'b1000: pc_d = target;
            4'b1001: pc_d = acc_zero ? target : pc_inc;
            4'b1010: pc_d = acc_zero ? pc_inc : target;
            4'b1111: state_d = S_DONE;
            default: pc_d = pc_inc;
          endcase
        end
      end
      S_EXEC: begin
        pc_d     = pc_inc;
        icount_d = icount_inc;
        state_d  = S_DECODE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // abort freezes everything but the state, so an aborted EXEC is not retired
    if (abort) begin
      state_d  = S_IDLE;
      pc_d     = pc_q;
      aluop_d  = aluop_q;
      icount_d = icount_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      aluop_q  <= '0;
      icount_q <= '0;
      com_q    <= COM_NOP;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      exec_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      aluop_q  <= aluop_d;
      icount_q <= icount_d;
      com_q    <= (state_d == S_EXEC) ? SEL_W'(aluop_d) : COM_NOP;
      busy_q   <= (state_d == S_DECODE) || (state_d == S_EXEC);
      done_q   <= (state_d == S_DONE);
      exec_q   <= (state_d == S_EXEC);
    end
  end

  // operand comes straight from the ROM in the EXEC cycle
  assign datain    = exec_q ? imem_data : '0;
  assign com       = com_q;
  assign imem_addr = pc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign icount    = icount_q;

endmodule

// File: tb/tb_dpath_seq.sv
// Scoreboard bench for dpath_seq: stimulus queues expected ALU issues, done pulses and
// per-cycle snapshots; a negedge monitor pops and compares them.
module tb_dpath_seq;

  localparam int SEL_W  = 3;
  localparam int DATA_W = 16;

  localparam int S_ADDR = 0, S_BUSY = 1, S_DONE = 2, S_COM = 3, S_DIN = 4, S_ICNT = 5;
  localparam int S_WADDR = 6, S_WCOM = 7, S_WDIN = 8, S_WICNT = 9, S_WDONE = 10, S_WBUSY = 11;

  typedef struct { int unsigned cyc; int sel; logic [15:0] val; } snap_t;
  typedef struct { int unsigned cyc; logic [2:0] c; logic [15:0] d; } op_t;
  typedef struct { int unsigned cyc; logic [15:0] ic; } done_t;

  logic clk = 1'b0;
  logic rst_n, start, abort, w_start, w_abort;
  logic [DATA_W-1:0] acc, w_acc;
  logic [15:0] rom [256];
  logic [15:0] rom_w [16];

  logic [7:0]        imem_addr;
  logic [DATA_W-1:0] imem_data, datain;
  logic [SEL_W-1:0]  com;
  logic              busy, done;
  logic [15:0]       icount;

  logic [3:0]        w_imem_addr;
  logic [DATA_W-1:0] w_imem_data, w_datain;
  logic [SEL_W-1:0]  w_com;
  logic              w_busy, w_done;
  logic [15:0]       w_icount;

  int unsigned cyc = 0;
  int unsigned base;
  int n_vec = 0;
  int n_fail = 0;
  logic final_chk;

  snap_t snap_q[$];
  op_t   op_q[$];
  done_t done_q[$];

  assign imem_data   = rom[imem_addr];
  assign w_imem_data = rom_w[w_imem_addr];

  dpath_seq u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .imem_addr(imem_addr), .imem_data(imem_data), .accum(acc),
    .com(com), .datain(datain), .busy(busy), .done(done), .icount(icount)
  );

  dpath_seq #(.ADDR_W(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(w_start), .abort(w_abort),
    .imem_addr(w_imem_addr), .imem_data(w_imem_data), .accum(w_acc),
    .com(w_com), .datain(w_datain), .busy(w_busy), .done(w_done), .icount(w_icount)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] sample(int sel);
    case (sel)
      S_ADDR:  return 16'(imem_addr);
      S_BUSY:  return 16'(busy);
      S_DONE:  return 16'(done);
      S_COM:   return 16'(com);
      S_DIN:   return datain;
      S_ICNT:  return icount;
      S_WADDR: return 16'(w_imem_addr);
      S_WCOM:  return 16'(w_com);
      S_WDIN:  return w_datain;
      S_WICNT: return w_icount;
      S_WDONE: return 16'(w_done);
      default: return 16'(w_busy);
    endcase
  endfunction

  function automatic string sname(int sel);
    case (sel)
      S_ADDR:  return "imem_addr";
      S_BUSY:  return "busy";
      S_DONE:  return "done";
      S_COM:   return "com";
      S_DIN:   return "datain";
      S_ICNT:  return "icount";
      S_WADDR: return "wrap_imem_addr";
      S_WCOM:  return "wrap_com";
      S_WDIN:  return "wrap_datain";
      S_WICNT: return "wrap_icount";
      S_WDONE: return "wrap_done";
      default: return "wrap_busy";
    endcase
  endfunction

  snap_t       m_s;
  op_t         m_o;
  done_t       m_d;
  logic [15:0] m_act;

  always @(negedge clk) begin
    n_vec++;
    if (com != 3'b000) begin
      if (op_q.size() == 0) begin
        n_fail++;
        $display("FAIL exec_op: unexpected com=%b datain=%h at cycle %0d", com, datain, cyc);
      end else begin
        m_o = op_q.pop_front();
        if (m_o.c != com || m_o.d != datain || m_o.cyc != cyc) begin
          n_fail++;
          $display("FAIL exec_op: got com=%b datain=%h cycle %0d, expected com=%b datain=%h cycle %0d",
                   com, datain, cyc, m_o.c, m_o.d, m_o.cyc);
        end
      end
    end else if (datain != '0) begin
      n_fail++;
      $display("FAIL idle_datain: got %h expected 0000 at cycle %0d", datain, cyc);
    end
    if (done) begin
      n_vec++;
      if (done_q.size() == 0) begin
        n_fail++;
        $display("FAIL done_pulse: unexpected done at cycle %0d (icount=%0d)", cyc, icount);
      end else begin
        m_d = done_q.pop_front();
        if (m_d.ic != icount || m_d.cyc != cyc) begin
          n_fail++;
          $display("FAIL done_pulse: got icount=%0d cycle %0d, expected icount=%0d cycle %0d",
                   icount, cyc, m_d.ic, m_d.cyc);
        end
      end
    end
    while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
      m_s = snap_q.pop_front();
      m_act = sample(m_s.sel);
      n_vec++;
      if (m_s.cyc != cyc || m_act != m_s.val) begin
        n_fail++;
        $display("FAIL snap_%s: got %h at cycle %0d, expected %h at cycle %0d",
                 sname(m_s.sel), m_act, cyc, m_s.val, m_s.cyc);
      end
    end
    if (final_chk) begin
      n_vec++;
      if (op_q.size() != 0 || done_q.size() != 0 || snap_q.size() != 0) begin
        n_fail++;
        $display("FAIL leftover: got ops=%0d dones=%0d snaps=%0d pending, expected none",
                 op_q.size(), done_q.size(), snap_q.size());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(int dc, int sel, logic [15:0] v);
    snap_q.push_back('{base + dc, sel, v});
  endtask

  task automatic exp_op(int dc, logic [2:0] c, logic [15:0] d);
    op_q.push_back('{base + dc, c, d});
  endtask

  task automatic exp_done(int dc, logic [15:0] ic);
    done_q.push_back('{base + dc, ic});
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; w_start = 1'b0; w_abort = 1'b0;
    acc = '0; w_acc = '0; final_chk = 1'b0;
    fill_rom();
    for (int i = 0; i < 16; i++) rom_w[i] = 16'hF000;

    // reset state
    tick();
    base = cyc;
    chk(0, S_ADDR, 0); chk(0, S_COM, 0); chk(0, S_DIN, 0); chk(0, S_BUSY, 0);
    chk(0, S_DONE, 0); chk(0, S_ICNT, 0); chk(0, S_WADDR, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // two ALU instructions then HALT
    fill_rom();
    rom[0] = 16'h1000; rom[1] = 16'h2222; rom[2] = 16'h6000; rom[3] = 16'h3333;
    base = cyc; start = 1'b1;
    exp_op(2, 3'b001, 16'h2222); exp_op(4, 3'b110, 16'h3333); exp_done(6, 3);
    chk(1, S_BUSY, 1); chk(1, S_ADDR, 0); chk(3, S_ADDR, 2); chk(5, S_ADDR, 4);
    chk(6, S_ADDR, 4); chk(7, S_DONE, 0); chk(7, S_BUSY, 0);
    tick(); start = 1'b0;
    repeat (8) tick();

    // JZ taken
    fill_rom();
    rom[0] = 16'h9004;
    acc = 16'd0;
    base = cyc; start = 1'b1;
    chk(1, S_ADDR, 0); chk(2, S_ADDR, 4); exp_done(3, 2);
    tick(); start = 1'b0;
    repeat (5) tick();

    // JZ not taken
    acc = 16'd5;
    base = cyc; start = 1'b1;
    chk(1, S_ADDR, 0); chk(2, S_ADDR, 1); exp_done(3, 2);
    tick(); start = 1'b0;
    repeat (5) tick();

    // JNZ loop: accum decremented after each JNZ decode
    fill_rom();
    rom[0] = 16'hB000; rom[1] = 16'hB000; rom[2] = 16'hA000; rom[3] = 16'hF000;
    acc = 16'd3;
    base = cyc; start = 1'b1;
    chk(3, S_ADDR, 2); chk(4, S_ADDR, 0); chk(7, S_ADDR, 0); chk(10, S_ADDR, 0);
    chk(12, S_ADDR, 2); chk(13, S_ADDR, 3); exp_done(14, 13);
    tick(); start = 1'b0;
    repeat (3) tick(); acc = 16'd2;
    repeat (3) tick(); acc = 16'd1;
    repeat (3) tick(); acc = 16'd0;
    repeat (6) tick();

    // pc wrap with a 4-bit PC: ALU opword at 0xF, operand at 0x0
    rom_w[0] = 16'h800F; rom_w[15] = 16'h1000; rom_w[1] = 16'hF000;
    base = cyc; w_start = 1'b1;
    chk(1, S_WADDR, 0); chk(2, S_WADDR, 15); chk(3, S_WADDR, 0); chk(3, S_WCOM, 1);
    chk(3, S_WDIN, 16'h800F); chk(3, S_WBUSY, 1); chk(4, S_WADDR, 1);
    chk(5, S_WDONE, 1); chk(5, S_WICNT, 3);
    tick(); w_start = 1'b0;
    repeat (6) tick();

    // abort during EXEC
    fill_rom();
    rom[0] = 16'hB000; rom[1] = 16'h1000; rom[2] = 16'h4444; rom[3] = 16'hF000;
    base = cyc; start = 1'b1;
    exp_op(3, 3'b001, 16'h4444);
    chk(4, S_BUSY, 0); chk(4, S_COM, 0); chk(4, S_DONE, 0); chk(4, S_ICNT, 1);
    chk(5, S_DONE, 0);
    tick(); start = 1'b0;
    tick();
    tick(); abort = 1'b1;
    tick(); abort = 1'b0;
    tick();

    // start and abort together in IDLE
    base = cyc; start = 1'b1; abort = 1'b1;
    chk(1, S_BUSY, 0); chk(2, S_BUSY, 0);
    tick(); start = 1'b0; abort = 1'b0;
    tick();

    // restart after abort
    base = cyc; start = 1'b1;
    chk(1, S_ADDR, 0); chk(1, S_ICNT, 0); exp_op(3, 3'b001, 16'h4444);
    chk(4, S_ADDR, 3); chk(4, S_ICNT, 2); exp_done(5, 3);
    tick(); start = 1'b0;
    repeat (6) tick();

    // start while busy ignored, then async reset mid-EXEC
    fill_rom();
    rom[0] = 16'hB000; rom[1] = 16'h1000; rom[2] = 16'h5555; rom[3] = 16'hF000;
    base = cyc; start = 1'b1;
    chk(1, S_ADDR, 0); chk(1, S_ICNT, 0); chk(2, S_ADDR, 1); chk(2, S_ICNT, 1);
    chk(3, S_ADDR, 0); chk(3, S_COM, 0); chk(3, S_DIN, 0); chk(3, S_BUSY, 0);
    chk(3, S_DONE, 0); chk(3, S_ICNT, 0); chk(5, S_BUSY, 0);
    tick();
    tick(); start = 1'b0;
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    repeat (3) tick();

    final_chk = 1'b1;
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/dpath_seq.md
# dpath_seq

Program sequencer for the accumulator datapath `dpath`. It fetches instructions from an asynchronous-read program ROM and drives `dpath`'s `com`/`datain` pair one ALU operation at a time. It executes unconditional and accumulator-conditional jumps, and stops on HALT. It sits between a host `start` pulse and the `dpath` instance, and is the only driver of `dpath.com` and `dpath.datain`.

## Interface
- `SEL_W`, default `` `SEL_W `` (3): width of the dpath command.
- `DATA_W`, default `` `DATA_W `` (16): data and ROM word width.
- `ADDR_W`, default 8: ROM address width; PC width.
- `COM_NOP`, default 3'b000: dpath command that leaves `accum` unchanged.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: reset; asynchronous, active-low.
- `start`  in  1: begin execution at address 0; sampled only in IDLE.
- `abort`  in  1: synchronous abort; returns to IDLE at the next edge from any state.
- `imem_addr`  out  ADDR_W: ROM address; ROM data is valid in the same cycle.
- `imem_data`  in  DATA_W: ROM read data.
- `accum`  in  DATA_W: current `dpath.accum`.
- `com`  out  SEL_W: to `dpath.com`.
- `datain`  out  DATA_W: to `dpath.datain`.
- `busy`  out  1: high in DECODE and EXEC.
- `done`  out  1: one-cycle pulse on HALT completion.
- `icount`  out  16: instructions retired since the last start; saturates at 16'hFFFF.

## Operation
Opword fields: `op` = `imem_data[15:12]`, target = `imem_data[ADDR_W-1:0]`.
- `op[3]==0`: ALU instruction, two words long. `com` = `op[2:0]`; the operand is the next ROM word.
- 4'b1000 JMP: pc <= target.
- 4'b1001 JZ: pc <= target if `accum == 0`, else pc+1.
- 4'b1010 JNZ: pc <= target if `accum != 0`, else pc+1.
- 4'b1111 HALT.
- Any other opcode is a NOP: pc+1, one word.

States and transitions:
- IDLE. On `start`: pc <= 0, icount <= 0, go to DECODE. `imem_addr` = pc.
- DECODE. `imem_addr` = pc.
  - ALU: go to EXEC with pc <= pc+1.
  - JMP/JZ/JNZ/NOP: update pc, icount+1, stay in DECODE.
  - HALT: icount+1, go to DONE.
- EXEC. `imem_addr` = pc (the operand word), `com` = latched `op[2:0]`, `datain` = `imem_data`. dpath applies the operation at the end of this cycle. Then pc <= pc+1, icount+1, go to DECODE.
- DONE. `done`=1 for one cycle, then go to IDLE. pc holds the HALT address.

Rules in every state:
- `com` = COM_NOP and `datain` = 0 in every state except EXEC. dpath is never modified outside EXEC.
- `abort` has priority over every transition. The state goes to IDLE without a `done` pulse. A `com` issued in the aborted EXEC cycle still takes effect; `icount` does not increment.
- pc arithmetic is modulo 2^ADDR_W: pc+1 from all-ones wraps to 0, including for an operand fetch.
- The latched ALU opcode is a 3-bit register written in DECODE.

## Timing
- Reset values: state IDLE, pc 0, `imem_addr` 0, `com` COM_NOP, `datain` 0, `busy` 0, `done` 0, `icount` 0. Reset mid-program abandons it immediately; no outputs glitch beyond the asynchronous clear.
- Latency:
  - `start` to first DECODE: 1 cycle.
  - ALU instruction: 2 cycles.
  - Jump or NOP: 1 cycle.
  - HALT to `done`: 1 cycle after DECODE of HALT.
- Conditional jumps read `accum` combinationally in DECODE. After an EXEC, the DECODE in the next cycle sees the updated accum, so no extra stall is required.
- `start` in any state other than IDLE is ignored. `start` and `abort` together in IDLE: abort wins, and the state stays IDLE.
- `icount` saturates and never wraps.

## Test plan
- Reset, then start, with ROM = {0x1000, 0x2222, 0x6000, 0x3333, 0xF000}. Required:
  - `com`/`datain` = 001/2222 in cycle 2 and 110/3333 in cycle 4; COM_NOP in every other cycle.
  - `done` in cycle 6; `icount` = 3.
- JZ taken and not taken, ROM = {0x9004, 0xF000, x, x, 0xF000} with the bench driving `accum`:
  - `accum` = 0: `imem_addr` goes 0 → 4 and `done` follows.
  - `accum` = 5: `imem_addr` goes 0 → 1.
- Loop with JNZ at address 2 targeting 0 and a bench-decremented `accum` from 3: exactly 3 back-edges, then HALT; `icount` is correct.
- Wrap, with ADDR_W = 4 and an ALU opword at 0xF: operand fetched from 0x0, next DECODE at 0x1.
- `abort` asserted during EXEC: the state is IDLE on the next edge, with no `done`, `busy` = 0, `com` = COM_NOP. A subsequent `start` restarts at 0 with `icount` = 0.
- `rst_n` dropped mid-EXEC (asynchronously, between edges): all outputs take their reset values immediately. `start` while busy has no effect on pc.
